// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - fetch-stage program-counter generator; optional counters under PC_GEN_PERF_EN
module pc_gen #(
  parameter int unsigned      WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_PC   = 32'h0000_3000,
  parameter logic [WIDTH-1:0] EXC_PC     = 32'h0000_4180,
  parameter logic [WIDTH-1:0] IMEM_BASE  = 32'h0000_3000,
  parameter logic [WIDTH-1:0] IMEM_BYTES = 32'h0000_4000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic [WIDTH-1:0] d_pc,
  input  logic [2:0]       br_type,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic [15:0]      imm16,
  input  logic [1:0]       j_type,
  input  logic [25:0]      j_index,
  input  logic [WIDTH-1:0] jr_data,
  input  logic             exc_req,
  input  logic             eret,
  input  logic [WIDTH-1:0] epc,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] npc,
  output logic             br_taken,
  output logic             f_adel
`ifdef PC_GEN_PERF_EN
  ,
  output logic [31:0]      cnt_redirect,
  output logic [31:0]      cnt_stall,
  output logic [31:0]      cnt_exc
`endif
);

  localparam logic [WIDTH-1:0] FOUR   = WIDTH'(4);
  // Window bounds widened by one bit so BASE + BYTES cannot overflow.
  localparam logic [WIDTH:0]   WIN_LO = {1'b0, IMEM_BASE};
  localparam logic [WIDTH:0]   WIN_HI = {1'b0, IMEM_BASE} + {1'b0, IMEM_BYTES};

  logic [WIDTH-1:0] d_pc_plus4;
  logic [WIDTH-1:0] br_off;
  logic [WIDTH-1:0] br_target;
  logic [WIDTH-1:0] j_target;
  logic [WIDTH:0]   npc_ext;
  logic             rs_neg;
  logic             rs_zero;
  logic             br_cond;
  logic             hold;
  logic             adel_next;

  assign d_pc_plus4 = d_pc + FOUR;
  assign br_off     = {{(WIDTH-18){imm16[15]}}, imm16, 2'b00};
  assign br_target  = d_pc_plus4 + br_off;
  assign rs_neg     = rs_val[WIDTH-1];
  assign rs_zero    = (rs_val == '0);

  // Jump region comes from the delay-slot PC; a 28-bit core has no region bits.
  generate
    if (WIDTH > 28) begin : g_jseg
      assign j_target = {d_pc_plus4[WIDTH-1:28], j_index, 2'b00};
    end else begin : g_jnoseg
      assign j_target = {j_index, 2'b00};
    end
  endgenerate

  // Branch condition evaluation on forwarded operands (relational ones signed).
  always_comb begin
    br_cond = 1'b0;
    case (br_type)
      3'd1:    br_cond = (rs_val == rt_val);
      3'd2:    br_cond = (rs_val != rt_val);
      3'd3:    br_cond = rs_neg | rs_zero;
      3'd4:    br_cond = ~rs_neg & ~rs_zero;
      3'd5:    br_cond = rs_neg;
      3'd6:    br_cond = ~rs_neg;
      default: br_cond = 1'b0;
    endcase
  end

  // Next-PC priority mux: exception, eret, stall, jump, jr, branch, sequential.
  always_comb begin
    npc      = pc + FOUR;
    br_taken = 1'b0;
    if (exc_req) begin
      npc = EXC_PC;
    end else if (eret) begin
      npc = epc;
    end else if (stall) begin
      npc = pc;
    end else if (j_type == 2'd1) begin
      npc      = j_target;
      br_taken = 1'b1;
    end else if (j_type == 2'd2) begin
      npc      = jr_data;
      br_taken = 1'b1;
    end else if (br_cond) begin
      npc      = br_target;
      br_taken = 1'b1;
    end
  end

  assign hold      = stall & ~exc_req & ~eret;
  assign npc_ext   = {1'b0, npc};
  assign adel_next = (npc[1:0] != 2'b00) || (npc_ext < WIN_LO) || (npc_ext >= WIN_HI);

  // PC register and fetch-error flag; the flag holds with pc during a stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc     <= RESET_PC;
      f_adel <= 1'b0;
    end else begin
      pc <= npc;
      if (!hold) begin
        f_adel <= adel_next;
      end
    end
  end

`ifdef PC_GEN_PERF_EN
  // Event counters, free-wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_redirect <= '0;
      cnt_stall    <= '0;
      cnt_exc      <= '0;
    end else begin
      if (br_taken) cnt_redirect <= cnt_redirect + 32'd1;
      if (hold)     cnt_stall    <= cnt_stall + 32'd1;
      if (exc_req)  cnt_exc      <= cnt_exc + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - self-checking bench for pc_gen (vector table, sequences, random vs model)
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic [31:0] d_pc = '0;
  logic [2:0]  br_type = '0;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic [15:0] imm16 = '0;
  logic [1:0]  j_type = '0;
  logic [25:0] j_index = '0;
  logic [31:0] jr_data = '0;
  logic        exc_req = 1'b0;
  logic        eret = 1'b0;
  logic [31:0] epc = '0;
  logic [31:0] pc;
  logic [31:0] npc;
  logic        br_taken;
  logic        f_adel;
`ifdef PC_GEN_PERF_EN
  logic [31:0] cnt_redirect;
  logic [31:0] cnt_stall;
  logic [31:0] cnt_exc;
`endif

  int checks = 0;
  int errors = 0;

  pc_gen dut (
    .clk(clk), .reset(reset), .stall(stall), .d_pc(d_pc), .br_type(br_type),
    .rs_val(rs_val), .rt_val(rt_val), .imm16(imm16), .j_type(j_type),
    .j_index(j_index), .jr_data(jr_data), .exc_req(exc_req), .eret(eret),
    .epc(epc), .pc(pc), .npc(npc), .br_taken(br_taken), .f_adel(f_adel)
`ifdef PC_GEN_PERF_EN
    , .cnt_redirect(cnt_redirect), .cnt_stall(cnt_stall), .cnt_exc(cnt_exc)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        stall, exc, eret;
    logic [31:0] epc, d_pc;
    logic [2:0]  br_type;
    logic [31:0] rs, rt;
    logic [15:0] imm;
    logic [1:0]  j_type;
    logic [25:0] j_index;
    logic [31:0] jr;
    logic [31:0] exp_npc;
    logic        exp_taken;
    logic        exp_adel;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic add(input string name, input logic st, input logic ex, input logic er,
                     input logic [31:0] ep, input logic [31:0] dp, input logic [2:0] bt,
                     input logic [31:0] rs, input logic [31:0] rt, input logic [15:0] im,
                     input logic [1:0] jt, input logic [25:0] ji, input logic [31:0] jr,
                     input logic [31:0] en, input logic et, input logic ea);
    vec_t v;
    v.name = name; v.stall = st; v.exc = ex; v.eret = er; v.epc = ep; v.d_pc = dp;
    v.br_type = bt; v.rs = rs; v.rt = rt; v.imm = im; v.j_type = jt; v.j_index = ji;
    v.jr = jr; v.exp_npc = en; v.exp_taken = et; v.exp_adel = ea;
    vecs.push_back(v);
  endtask

  task automatic idle();
    stall = 0; exc_req = 0; eret = 0; epc = '0; d_pc = '0; br_type = '0;
    rs_val = '0; rt_val = '0; imm16 = '0; j_type = '0; j_index = '0; jr_data = '0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Reference model: next fetch address straight from the priority rules.
  function automatic void model(input logic [31:0] cur, output logic [31:0] n, output logic tk);
    int rsi;
    logic cond;
    rsi  = int'(rs_val);
    cond = 0;
    case (int'(br_type))
      1: cond = (rs_val == rt_val);
      2: cond = (rs_val != rt_val);
      3: cond = (rsi <= 0);
      4: cond = (rsi > 0);
      5: cond = (rsi < 0);
      6: cond = (rsi >= 0);
      default: cond = 0;
    endcase
    tk = 0;
    n  = cur + 32'd4;
    if (exc_req)           n = 32'h0000_4180;
    else if (eret)         n = epc;
    else if (stall)        n = cur;
    else if (j_type == 1) begin
      n = ((d_pc + 32'd4) & 32'hF000_0000) | (32'(j_index) * 4); tk = 1;
    end else if (j_type == 2) begin
      n = jr_data; tk = 1;
    end else if (cond) begin
      n = d_pc + 32'd4 + 32'(int'($signed(imm16)) * 4); tk = 1;
    end
  endfunction

  function automatic logic model_adel(input logic [31:0] a);
    longint la;
    la = longint'(a);
    return (la % 4 != 0) || (la < 64'h3000) || (la >= 64'h3000 + 64'h4000);
  endfunction

  initial begin
    logic [31:0] m_pc, m_n;
    logic        m_adel, m_tk, m_hold;
    int          m_red, m_stl, m_exc;

    // Reset and free run
    @(posedge clk); #1;
    reset = 0;
    chk("reset_pc", pc, 32'h3000);
    chk("reset_adel", {31'b0, f_adel}, 32'd0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk($sformatf("freerun_pc%0d", i), pc, 32'h3000 + 32'(i * 4));
      chk($sformatf("freerun_adel%0d", i), {31'b0, f_adel}, 32'd0);
    end

    // Vector table, each applied from pc=0x3000 after reset
    //   name          st ex er epc          d_pc         bt rs            rt    imm       jt ji          jr            npc          tk adel
    add("beq_taken",   0, 0, 0, 0,           32'h3010,    1, 5,            5,    16'hFFFC, 0, 0,          0,            32'h3004,    1, 0);
    add("bne_not",     0, 0, 0, 0,           32'h3010,    2, 5,            5,    16'hFFFC, 0, 0,          0,            32'h3004,    0, 0);
    add("bltz_taken",  0, 0, 0, 0,           32'h3100,    5, 32'h80000000, 0,    16'h0010, 0, 0,          0,            32'h3144,    1, 0);
    add("bgez_not",    0, 0, 0, 0,           32'h3100,    6, 32'h80000000, 0,    16'h0010, 0, 0,          0,            32'h3004,    0, 0);
    add("blez_zero",   0, 0, 0, 0,           32'h3100,    3, 0,            0,    16'h0010, 0, 0,          0,            32'h3144,    1, 0);
    add("bgtz_zero",   0, 0, 0, 0,           32'h3100,    4, 0,            0,    16'h0010, 0, 0,          0,            32'h3004,    0, 0);
    add("bgtz_one",    0, 0, 0, 0,           32'h3100,    4, 1,            0,    16'h0010, 0, 0,          0,            32'h3144,    1, 0);
    add("bne_taken",   0, 0, 0, 0,           32'h3200,    2, 1,            2,    16'h0003, 0, 0,          0,            32'h3210,    1, 0);
    add("j_index",     0, 0, 0, 0,           32'h3010,    0, 0,            0,    0,        1, 26'hC40,    0,            32'h3100,    1, 0);
    add("j_region",    0, 0, 0, 0,           32'h5FFFFFFC,0, 0,            0,    0,        1, 26'hC40,    0,            32'h60003100,1, 1);
    add("jr_misalign", 0, 0, 0, 0,           0,           0, 0,            0,    0,        2, 0,          32'h3002,     32'h3002,    1, 1);
    add("jr_top_out",  0, 0, 0, 0,           0,           0, 0,            0,    0,        2, 0,          32'h7000,     32'h7000,    1, 1);
    add("jr_top_in",   0, 0, 0, 0,           0,           0, 0,            0,    0,        2, 0,          32'h6FFC,     32'h6FFC,    1, 0);
    add("jr_below",    0, 0, 0, 0,           0,           0, 0,            0,    0,        2, 0,          32'h2FFC,     32'h2FFC,    1, 1);
    add("jr_high",     0, 0, 0, 0,           0,           0, 0,            0,    0,        2, 0,          32'hFFFFFFFC, 32'hFFFFFFFC,1, 1);
    add("exc_all",     1, 1, 1, 32'h3024,    32'h3010,    1, 5,            5,    16'hFFFC, 1, 26'hC40,    0,            32'h4180,    0, 0);
    add("eret_stall",  1, 0, 1, 32'h3024,    32'h3010,    1, 5,            5,    16'hFFFC, 2, 0,          32'h5000,     32'h3024,    0, 0);
    add("stall_jump",  1, 0, 0, 0,           32'h3010,    0, 0,            0,    0,        1, 26'hC40,    0,            32'h3000,    0, 0);
    add("br_rsvd",     0, 0, 0, 0,           32'h3010,    7, 5,            5,    16'hFFFC, 0, 0,          0,            32'h3004,    0, 0);
    add("j_rsvd",      0, 0, 0, 0,           32'h3010,    0, 0,            0,    0,        3, 26'hC40,    32'h5000,     32'h3004,    0, 0);
    add("j_over_br",   0, 0, 0, 0,           32'h3010,    1, 5,            5,    16'hFFFC, 1, 26'hC40,    0,            32'h3100,    1, 0);

    foreach (vecs[k]) begin
      do_reset();
      stall = vecs[k].stall; exc_req = vecs[k].exc; eret = vecs[k].eret; epc = vecs[k].epc;
      d_pc = vecs[k].d_pc; br_type = vecs[k].br_type; rs_val = vecs[k].rs; rt_val = vecs[k].rt;
      imm16 = vecs[k].imm; j_type = vecs[k].j_type; j_index = vecs[k].j_index; jr_data = vecs[k].jr;
      @(negedge clk);
      chk({vecs[k].name, "_npc"}, npc, vecs[k].exp_npc);
      chk({vecs[k].name, "_taken"}, {31'b0, br_taken}, {31'b0, vecs[k].exp_taken});
      tick();
      chk({vecs[k].name, "_pc"}, pc, vecs[k].exp_npc);
      chk({vecs[k].name, "_adel"}, {31'b0, f_adel}, {31'b0, vecs[k].exp_adel});
    end

    // Stall holds a pending jump for two cycles, then the jump lands
    do_reset();
    stall = 1; j_type = 1; j_index = 26'hC40; d_pc = 32'h3010;
    tick(); chk("stall_hold1", pc, 32'h3000);
    tick(); chk("stall_hold2", pc, 32'h3000);
    stall = 0;
    @(negedge clk); chk("stall_release_taken", {31'b0, br_taken}, 32'd1);
    tick(); chk("stall_release_pc", pc, 32'h3100);

    // Exception beats eret and stall at pc=0x3020, then eret returns
    do_reset();
    for (int i = 0; i < 8; i++) tick();
    chk("exc_seq_start", pc, 32'h3020);
    exc_req = 1; eret = 1; stall = 1; epc = 32'h3024;
    tick(); chk("exc_seq_entry", pc, 32'h4180);
    exc_req = 0; stall = 0;
    tick(); chk("exc_seq_eret", pc, 32'h3024);
    eret = 0;

    // Stall freezes a set fetch-error flag together with pc
    do_reset();
    j_type = 2; jr_data = 32'h3002;
    tick();
    idle(); stall = 1;
    tick(); chk("adel_hold_pc", pc, 32'h3002);
    chk("adel_hold_flag", {31'b0, f_adel}, 32'd1);

    // Reset overrides stall and exception
    idle(); reset = 1; stall = 1; exc_req = 1;
    tick(); reset = 0; idle();
    chk("reset_override_pc", pc, 32'h3000);
    chk("reset_override_adel", {31'b0, f_adel}, 32'd0);

`ifdef PC_GEN_PERF_EN
    // Three taken branches and two stalls
    do_reset();
    chk("perf_reset", cnt_redirect | cnt_stall | cnt_exc, 32'd0);
    br_type = 1; rs_val = 7; rt_val = 7; d_pc = 32'h3010; imm16 = 16'h0004;
    for (int i = 0; i < 3; i++) tick();
    idle(); stall = 1;
    for (int i = 0; i < 2; i++) tick();
    idle();
    chk("perf_redirect", cnt_redirect, 32'd3);
    chk("perf_stall", cnt_stall, 32'd2);
    chk("perf_exc", cnt_exc, 32'd0);
`endif

    // Randomized run against the model
    do_reset();
    m_pc = 32'h3000; m_adel = 0; m_red = 0; m_stl = 0; m_exc = 0;
    for (int i = 0; i < 3000; i++) begin
      reset   = ($urandom_range(0, 99) == 0);
      stall   = ($urandom_range(0, 3) == 0);
      exc_req = ($urandom_range(0, 19) == 0);
      eret    = ($urandom_range(0, 19) == 0);
      epc     = 32'h3000 + ($urandom_range(0, 32'h0FFF) << 2);
      d_pc    = ($urandom_range(0, 7) == 0) ? $urandom : 32'h3000 + ($urandom_range(0, 32'h0FFF) << 2);
      br_type = 3'($urandom_range(0, 7));
      rs_val  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 2)) - 32'd1 : $urandom;
      rt_val  = ($urandom_range(0, 1) == 0) ? rs_val : $urandom;
      imm16   = 16'($urandom);
      j_type  = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      j_index = 26'($urandom);
      jr_data = ($urandom_range(0, 1) == 0) ? 32'h3000 + $urandom_range(0, 32'h3FFF) : $urandom;
      model(m_pc, m_n, m_tk);
      m_hold = stall && !exc_req && !eret;
      @(negedge clk);
      if (!reset) begin
        chk($sformatf("rand%0d_npc", i), npc, m_n);
        chk($sformatf("rand%0d_taken", i), {31'b0, br_taken}, {31'b0, m_tk});
      end
      tick();
      if (reset) begin
        m_pc = 32'h3000; m_adel = 0; m_red = 0; m_stl = 0; m_exc = 0;
      end else begin
        if (!m_hold) m_adel = model_adel(m_n);
        m_pc = m_n;
        m_red += int'(m_tk); m_stl += int'(m_hold); m_exc += int'(exc_req);
      end
      chk($sformatf("rand%0d_pc", i), pc, m_pc);
      chk($sformatf("rand%0d_adel", i), {31'b0, f_adel}, {31'b0, m_adel});
    end
    reset = 0;
`ifdef PC_GEN_PERF_EN
    chk("rand_cnt_redirect", cnt_redirect, 32'(m_red));
    chk("rand_cnt_stall", cnt_stall, 32'(m_stl));
    chk("rand_cnt_exc", cnt_exc, 32'(m_exc));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
